alu_seq_nbit: RTL and testbench
===============================

# alu_seq_nbit

Parametrised N-bit ALU: next generation of the team's 1-bit ALU slice, with registered results, valid/ready handshaking, full status flags and multi-cycle shifts. Single-cycle logic ops and add/sub/SLT go through a combinational core. Logical shifts run iteratively, one bit per cycle, under a small state machine. The block sits between the register-read stage and writeback of the datapath.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 2
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  4  opcode {Ainvert, Binvert, sel[1:0]}
- a, b  in  WIDTH  operands; for shifts, shift amount = b[SHW-1:0]
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero, carry, overflow, negative, err  out  1 each  registered flags

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a + ~b + 1)
  - 0111 SLT (signed)
  - 1100 NOR (~a & ~b)
  - 1000 SLL
  - 1001 SRL
  - any other opcode: result 0, err=1, other flags 0
- Flags:
  - zero = (result == 0).
  - negative = result[WIDTH-1].
  - carry = adder carry-out for ADD/SUB/SLT, else 0. For SUB, carry=1 means no borrow.
  - overflow = signed overflow for ADD/SUB/SLT, else 0.
  - err = 0 for defined opcodes.
- SLT: result = {0…, less}, where less = diff[WIDTH-1] ^ overflow. This is correct across sign overflow.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: in_ready=1. On in_valid:
    - Non-shift op, or shift with amount 0: register the core output, go to DONE.
    - Shift with amount ≥ 1: load acc=a, cnt=amount, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle, acc shifts 1 bit (zero fill) and cnt decrements. On the cycle cnt==1, register the final acc as result and go to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready.
    - out_ready=1: in_ready=1 this cycle. If in_valid is also 1, the new request is accepted (handled as from IDLE); otherwise go to IDLE.
    - out_ready=0: in_ready=0.
- A request while in_ready=0 is ignored; a, b and op are not sampled.
- Reset (rst_n=0 at an edge) applies in any state, including mid-SHIFT:
  - state=IDLE, out_valid=0, result=0, all flags=0, acc/cnt=0.
  - in_ready is forced 0 while rst_n=0.

## Timing
- Non-shift op, or shift by 0: out_valid rises 1 cycle after the accept edge.
- Shift by k (1..WIDTH-1): out_valid rises k+1 cycles after the accept edge.
- Sustained throughput with out_ready held high: one single-cycle op per cycle, back-to-back through DONE.
- in_ready is combinational from state and out_ready only; there is no path from in_valid.
- All outputs except in_ready are registered.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_SLL, OP_SRL)
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE)
- Sub-module alu_core: purely combinational WIDTH-bit logic/add/sub/SLT.
  - Built as a ripple of full adders with operand inversion muxes.
  - Outputs result, carry, overflow and err.
- alu_seq_nbit holds the FSM, shift accumulator/counter, output registers and zero/negative flag generation.

## Test plan
All scenarios use WIDTH=8.
- ADD a=8'h7F, b=8'h01 → result 8'h80, overflow=1, carry=0, negative=1, zero=0; out_valid exactly 1 cycle after accept.
- SUB a=8'h05, b=8'h05 → result 8'h00, zero=1, carry=1, overflow=0. SLT a=8'h80, b=8'h7F → result 8'h01, overflow=1.
- SLL a=8'h01, b=3 → result 8'h08, out_valid 4 cycles after accept, in_ready=0 throughout SHIFT. SRL a=8'h80, b=7 → result 8'h01 after 8 cycles. SLL b=0 → 8'h01 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/flags stable, in_ready=0, new in_valid ignored. Then raise out_ready with in_valid=1, AND a=8'hF0, b=8'h3C → accepted same cycle, next result 8'h30.
- Drop rst_n for one edge during SLL by 5 → next cycle out_valid=0, result=0, flags=0; after release in_ready=1 and a fresh op completes normally.
- op=4'b1111 → result 8'h00, err=1, zero=0, carry=0, overflow=0, negative=0; the following valid op returns err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers for the sequential N-bit ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU core: operand inversion muxes feeding a full-adder ripple,
// plus AND/OR (NOR via inverted AND) and signed set-less-than.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    logic [WIDTH-1:0] a_inv_s;
    logic [WIDTH-1:0] b_inv_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   c_s;
    logic             ovf_s;
    logic             less_s;

    assign a_inv_s = op[3] ? ~a : a;
    assign b_inv_s = op[2] ? ~b : b;
    assign c_s[0]  = op[2];

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_s[i]  = a_inv_s[i] ^ b_inv_s[i] ^ c_s[i];
        assign c_s[i+1]  = (a_inv_s[i] & b_inv_s[i]) | (c_s[i] & (a_inv_s[i] ^ b_inv_s[i]));
    end

    assign ovf_s  = c_s[WIDTH] ^ c_s[WIDTH-1];
    // Sign of the difference corrected by overflow stays right across sign wrap.
    assign less_s = sum_s[WIDTH-1] ^ ovf_s;

    // Opcode decode into result and arithmetic flags
    always_comb begin
        result   = {WIDTH{1'b0}};
        carry    = 1'b0;
        overflow = 1'b0;
        err      = 1'b0;
        case (op)
            OP_AND, OP_NOR: result = a_inv_s & b_inv_s;
            OP_OR:          result = a_inv_s | b_inv_s;
            OP_ADD, OP_SUB: begin
                result   = sum_s;
                carry    = c_s[WIDTH];
                overflow = ovf_s;
            end
            OP_SLT: begin
                result   = {{(WIDTH-1){1'b0}}, less_s};
                carry    = c_s[WIDTH];
                overflow = ovf_s;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU: valid/ready handshake, registered result and flags,
// single-cycle core ops and one-bit-per-cycle logical shifts.
module alu_seq_nbit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             err
);

    state_e           state_r, state_nxt_s;
    logic [WIDTH-1:0] acc_r, shifted_s, core_res_s, cap_res_s, result_r;
    logic [SHW-1:0]   cnt_r, amt_s;
    logic             dir_r, is_shift_s, shift_run_s, start_s, load_s, cap_s, last_step_s;
    logic             core_carry_s, core_ovf_s, core_err_s;
    logic             cap_carry_s, cap_ovf_s, cap_err_s;
    logic             out_valid_r, zero_r, carry_r, overflow_r, negative_r, err_r;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (core_res_s),
        .carry    (core_carry_s),
        .overflow (core_ovf_s),
        .err      (core_err_s)
    );

    assign amt_s       = b[SHW-1:0];
    assign is_shift_s  = is_shift_op(op);
    assign shift_run_s = is_shift_s && (amt_s != {SHW{1'b0}});
    assign in_ready    = rst_n && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready));
    assign start_s     = in_valid && in_ready;
    assign load_s      = start_s && shift_run_s;
    assign last_step_s = (state_r == ST_SHIFT) && (cnt_r <= SHW'(1));
    assign cap_s       = (start_s && !shift_run_s) || last_step_s;
    assign shifted_s   = dir_r ? {1'b0, acc_r[WIDTH-1:1]} : {acc_r[WIDTH-2:0], 1'b0};

    // Choose the value to register: final shift step, unshifted operand, or core output
    always_comb begin
        cap_res_s   = core_res_s;
        cap_carry_s = core_carry_s;
        cap_ovf_s   = core_ovf_s;
        cap_err_s   = core_err_s;
        if (state_r == ST_SHIFT) begin
            cap_res_s   = shifted_s;
            cap_carry_s = 1'b0;
            cap_ovf_s   = 1'b0;
            cap_err_s   = 1'b0;
        end else if (is_shift_s) begin
            cap_res_s   = a;
            cap_carry_s = 1'b0;
            cap_ovf_s   = 1'b0;
            cap_err_s   = 1'b0;
        end else begin
            cap_res_s   = core_res_s;
            cap_carry_s = core_carry_s;
            cap_ovf_s   = core_ovf_s;
            cap_err_s   = core_err_s;
        end
    end

    // Next-state logic; DONE accepts a new request in the same cycle it is drained
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_nxt_s = shift_run_s ? ST_SHIFT : ST_DONE;
                end else if ((state_r == ST_DONE) && !out_ready) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: state_nxt_s = last_step_s ? ST_DONE : ST_SHIFT;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, shift datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {SHW{1'b0}};
            dir_r       <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            negative_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (load_s) begin
                acc_r <= a;
                cnt_r <= amt_s;
                dir_r <= op[0];
            end else if (state_r == ST_SHIFT) begin
                acc_r <= shifted_s;
                cnt_r <= cnt_r - SHW'(1);
            end
            if (cap_s) begin
                result_r   <= cap_res_s;
                zero_r     <= (cap_res_s == {WIDTH{1'b0}}) && !cap_err_s;
                negative_r <= cap_res_s[WIDTH-1];
                carry_r    <= cap_carry_s;
                overflow_r <= cap_ovf_s;
                err_r      <= cap_err_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;
    assign negative  = negative_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Bench for alu_seq_nbit at WIDTH=8: directed vectors with literal expectations plus a
// cycle-level reference model of the handshake and arithmetic checked every cycle.
module tb_alu_seq_nbit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'b0000;
    logic [W-1:0] a = 8'h00;
    logic [W-1:0] b = 8'h00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero, carry, overflow, negative, err;

    int total = 0;
    int bad   = 0;

    alu_seq_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic; packed as {result, carry, overflow, negative, zero, err}
    function automatic logic [12:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v, e;
        s = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[7:0]; c = s[8];
                v = (x[7] == y[7]) && (r[7] != x[7]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, x} + {1'b0, ~y} + 9'd1;
                r = s[7:0]; c = s[8];
                v = (x[7] != y[7]) && (r[7] != x[7]);
                if (o == 4'b0111) r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
            end
            4'b1100: r = ~(x | y);
            4'b1000: r = x << y[2:0];
            4'b1001: r = x >> y[2:0];
            default: e = 1'b1;
        endcase
        return {r, c, v, r[7], (r == 8'd0) && !e, e};
    endfunction

    // Model state: pending result, cycles still in flight, and last-reset marker
    logic        exp_vld = 1'b0;
    logic [12:0] exp_rec = 13'd0;
    logic [12:0] pend    = 13'd0;
    int          wait_n  = 0;
    logic        after_rst = 1'b1;
    logic        rdy_e;

    // Per-cycle compare against the model, then advance the model to the next edge
    always @(negedge clk) begin
        rdy_e = rst_n && (wait_n == 0) && (!exp_vld || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_e});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
        if (exp_vld)
            chk("outputs", {19'd0, result, carry, overflow, negative, zero, err}, {19'd0, exp_rec});
        else if (after_rst)
            chk("reset_outputs", {19'd0, result, carry, overflow, negative, zero, err}, 32'd0);
        if (!rst_n) begin
            exp_vld = 1'b0; wait_n = 0; after_rst = 1'b1;
        end else begin
            if (exp_vld && out_ready) exp_vld = 1'b0;
            if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) begin exp_vld = 1'b1; exp_rec = pend; end
            end
            if (in_valid && rdy_e) begin
                after_rst = 1'b0;
                pend = model(op, a, b);
                wait_n = (op[3:1] == 3'b100 && b[2:0] != 3'd0) ? int'(b[2:0]) : 0;
                if (wait_n == 0) begin exp_vld = 1'b1; exp_rec = pend; end
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [7:0] r, input logic e, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_latency"}, n, lat);
        chk({name, "_result"}, {24'd0, result}, {24'd0, r});
        chk({name, "_err"}, {31'd0, err}, {31'd0, e});
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model to hand-computed values
        chk("model_add", {19'd0, model(4'b0010, 8'h7F, 8'h01)}, {19'd0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("model_sub", {19'd0, model(4'b0110, 8'h05, 8'h05)}, {19'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        chk("model_slt", {19'd0, model(4'b0111, 8'h80, 8'h7F)}, {19'd0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("model_bad", {19'd0, model(4'b1111, 8'h55, 8'hAA)}, {19'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("model_srl", {19'd0, model(4'b1001, 8'h80, 8'h07)}, {19'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        send(4'b0010, 8'h7F, 8'h01); wait_result("add_ovf", 8'h80, 1'b0, 1);
        chk("add_flags", {28'd0, carry, overflow, negative, zero}, {28'd0, 4'b0110});
        send(4'b0110, 8'h05, 8'h05); wait_result("sub_eq", 8'h00, 1'b0, 1);
        send(4'b0111, 8'h80, 8'h7F); wait_result("slt_wrap", 8'h01, 1'b0, 1);
        send(4'b1000, 8'h01, 8'h03); wait_result("sll3", 8'h08, 1'b0, 4);
        send(4'b1001, 8'h80, 8'h07); wait_result("srl7", 8'h01, 1'b0, 8);
        send(4'b1000, 8'h01, 8'h00); wait_result("sll0", 8'h01, 1'b0, 1);

        // Back-to-back single-cycle ops with out_ready held high
        send(4'b0010, 8'h01, 8'h02);
        send(4'b0110, 8'h09, 8'h04);
        send(4'b1100, 8'hF0, 8'h0F); wait_result("b2b_nor", 8'h00, 1'b0, 1);

        // Backpressure: result held, new request ignored, then accepted on release
        out_ready = 1'b0;
        send(4'b0001, 8'h0F, 8'h30); wait_result("bp_or", 8'h3F, 1'b0, 1);
        op = 4'b0010; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        op = 4'b0000; a = 8'hF0; b = 8'h3C; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        wait_result("bp_and", 8'h30, 1'b0, 1);

        // Reset in the middle of a shift
        send(4'b1000, 8'h03, 8'h05);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #2;
        send(4'b0010, 8'h03, 8'h04); wait_result("post_rst_add", 8'h07, 1'b0, 1);

        // Undefined opcode, then recovery
        send(4'b1111, 8'h55, 8'hAA); wait_result("bad_op", 8'h00, 1'b1, 1);
        chk("bad_op_flags", {28'd0, carry, overflow, negative, zero}, 32'd0);
        send(4'b0010, 8'h01, 8'h02); wait_result("after_bad", 8'h03, 1'b0, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
